// File: rtl/branch_predictor_2lvl.sv
// branch_predictor_2lvl
//   Two-level dynamic branch predictor. A direct-mapped BTB holds a tag,
//   a target and a local history register per entry. A shared PHT of
//   saturating counters is indexed by pc XOR local history. After reset an
//   INIT sweep clears the BTB and sets every counter to weakly not-taken.
//   Once the sweep is done, the block accepts one lookup and one update
//   per cycle.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   lk_valid, lk_pc        lookup request
//   lk_ready               high once the INIT sweep has finished (registered)
//   pr_valid               registered prediction, one cycle after a lookup
//   pr_hit                 BTB hit for that prediction
//   pr_taken               predicted direction
//   pr_target              predicted next PC
//   up_valid, up_pc,       resolved-branch update (direction and target)
//   up_taken, up_target
module branch_predictor_2lvl #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6,
    parameter int PHT_W  = 8,
    parameter int HIST_W = 4,
    parameter int CTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lk_valid,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_ready,
    output logic              pr_valid,
    output logic              pr_hit,
    output logic              pr_taken,
    output logic [ADDR_W-1:0] pr_target,
    input  logic              up_valid,
    input  logic [ADDR_W-1:0] up_pc,
    input  logic              up_taken,
    input  logic [ADDR_W-1:0] up_target
);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int BTB_N = 1 << IDX_W;
    localparam int PHT_N = 1 << PHT_W;
    localparam int SW    = (IDX_W > PHT_W) ? IDX_W : PHT_W;

    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] ptr_q;

    logic [BTB_N-1:0]  btb_valid;
    logic [TAG_W-1:0]  btb_tag  [BTB_N];
    logic [ADDR_W-1:0] btb_tgt  [BTB_N];
    logic [HIST_W-1:0] btb_hist [BTB_N];
    logic [CTR_W-1:0]  pht      [PHT_N];

    // The two low PC bits are always zero for aligned instructions.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lk_pc[1:0], up_pc[1:0]};

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (ptr_q == {SW{1'b1}}) state_d = READY;
            READY:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    // lk_ready mirrors state_q == READY, but as its own flop so that the
    // output is registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= INIT;
            ptr_q    <= '0;
            lk_ready <= 1'b0;
        end else begin
            state_q  <= state_d;
            lk_ready <= (state_d == READY);
            if (state_q == INIT) ptr_q <= ptr_q + 1'b1;
        end
    end

    // ---------------- lookup path ----------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [PHT_W-1:0] lk_pht_idx;

    assign lk_idx     = lk_pc[IDX_W+1:2];
    assign lk_tag     = lk_pc[ADDR_W-1:IDX_W+2];
    assign lk_hit     = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    assign lk_pht_idx = lk_pc[PHT_W+1:2] ^ PHT_W'(btb_hist[lk_idx]);

    // ---------------- update path ----------------
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             up_en;
    logic [PHT_W-1:0] up_pht_idx;
    logic [CTR_W-1:0] up_ctr, ctr_next;

    assign up_idx = up_pc[IDX_W+1:2];
    assign up_tag = up_pc[ADDR_W-1:IDX_W+2];
    assign up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
    // Only hits and taken misses change state; not-taken misses are dropped.
    assign up_en  = up_valid && lk_ready && (up_hit || up_taken);

    // A freshly allocated branch trains the counter with history 0.
    assign up_pht_idx = up_hit ? (up_pc[PHT_W+1:2] ^ PHT_W'(btb_hist[up_idx]))
                               : up_pc[PHT_W+1:2];
    assign up_ctr     = pht[up_pht_idx];

    always_comb begin
        ctr_next = up_ctr;
        if (up_taken) begin
            if (up_ctr != CTR_MAX) ctr_next = up_ctr + 1'b1;
        end else begin
            if (up_ctr != '0) ctr_next = up_ctr - 1'b1;
        end
    end

    // BTB storage: the INIT sweep clears valid/hist; in READY it is written by updates.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == INIT) begin
                if ((ptr_q >> IDX_W) == '0) begin
                    btb_valid[ptr_q[IDX_W-1:0]] <= 1'b0;
                    btb_hist[ptr_q[IDX_W-1:0]]  <= '0;
                end
            end else if (up_en) begin
                if (up_hit) begin
                    // Shift in the outcome; truncation drops the oldest bit.
                    btb_hist[up_idx] <= HIST_W'({btb_hist[up_idx], up_taken});
                    if (up_taken) btb_tgt[up_idx] <= up_target;
                end else begin
                    btb_valid[up_idx] <= 1'b1;
                    btb_tag[up_idx]   <= up_tag;
                    btb_tgt[up_idx]   <= up_target;
                    btb_hist[up_idx]  <= HIST_W'(1);
                end
            end
        end
    end

    // PHT storage.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == INIT) begin
                if ((ptr_q >> PHT_W) == '0) pht[ptr_q[PHT_W-1:0]] <= CTR_INIT;
            end else if (up_en) begin
                pht[up_pht_idx] <= ctr_next;
            end
        end
    end

    // ---------------- prediction register ----------------
    // The prediction reads pre-update state. When pr_valid is low, the data fields hold their last values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pr_valid  <= 1'b0;
            pr_hit    <= 1'b0;
            pr_taken  <= 1'b0;
            pr_target <= '0;
        end else if (lk_valid && lk_ready) begin
            pr_valid  <= 1'b1;
            pr_hit    <= lk_hit;
            pr_taken  <= lk_hit ? pht[lk_pht_idx][CTR_W-1] : 1'b0;
            pr_target <= lk_hit ? btb_tgt[lk_idx] : lk_pc + ADDR_W'(4);
        end else begin
            pr_valid  <= 1'b0;
        end
    end

endmodule
